kernel_window_scheduler: RTL and testbench

Sequencer that drives a single 3x3 kernel unit across the interior of a padded N x N image held in image RAM. For every interior pixel it fetches the nine neighbourhood values in a fixed raster order, streams them into the kernel unit tagged with an identifier, waits for the kernel result, and writes that result to the result RAM at the centre address. One `start` pulse runs one full pass. Padding pixels (row/col 0 and N-1) are never visited or written.

---
 rtl/kernel_window_scheduler_if.sv | 33 +++
 rtl/kernel_window_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_kernel_window_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_window_scheduler_if.sv
// Bundles the image RAM read port, kernel-unit load/result port, result RAM write port and pass status.
// The scheduler uses the master modport; the RAMs and kernel unit sit on the slave side.
interface kernel_window_scheduler_if #(
  parameter int bitSize = 6
);
  logic               start;
  logic               img_re;
  logic [bitSize:0]   img_addr;
  logic [7:0]         img_data;
  logic               k_we;
  logic [7:0]         k_id;
  logic [7:0]         k_data;
  logic [7:0]         k_result;
  logic               k_result_valid;
  logic               res_we;
  logic [bitSize:0]   res_addr;
  logic [7:0]         res_data;
  logic               busy;
  logic               done;
  logic [15:0]        changed_count;

  modport master (
    input  start, img_data, k_result, k_result_valid,
    output img_re, img_addr, k_we, k_id, k_data, res_we, res_addr, res_data,
           busy, done, changed_count
  );

  modport slave (
    output start, img_data, k_result, k_result_valid,
    input  img_re, img_addr, k_we, k_id, k_data, res_we, res_addr, res_data,
           busy, done, changed_count
  );
endinterface

// File: rtl/kernel_window_scheduler.sv
// Walks the interior of a padded N x N image, streams each 3x3 neighbourhood to the kernel unit, writes its result at the centre address.
// 12 cycles/pixel with k_result_valid held high; stalls in WAIT with no timeout. Define CHANGE_COUNT_EN to build the changed-pixel counter.
module kernel_window_scheduler #(
  parameter int N       = 8,
  parameter int bitSize = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  kernel_window_scheduler_if.master   bus
);
  localparam int AW = bitSize + 1;
  localparam logic [AW-1:0] POS_FIRST = AW'(1);
  localparam logic [AW-1:0] POS_LAST  = AW'(N - 2);
  localparam logic [AW-1:0] N_W       = AW'(N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [AW-1:0] r_q, r_d, c_q, c_d;
  logic          img_re_q, img_re_d;
  logic [AW-1:0] img_addr_q, img_addr_d;
  logic          k_we_q, k_we_d;
  logic [7:0]    k_id_q, k_id_d;
  logic          res_we_q, res_we_d;
  logic [AW-1:0] res_addr_q, res_addr_d;
  logic [7:0]    res_data_q, res_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Neighbour i sits at (r-1+i/3, c-1+i%3), flattened row-major.
  function automatic logic [AW-1:0] nbr_addr(input logic [AW-1:0] r, input logic [AW-1:0] c,
                                             input logic [3:0] i);
    logic [AW-1:0] ro;
    logic [AW-1:0] co;
    if (i >= 4'd6) begin
      ro = AW'(2);
    end else if (i >= 4'd3) begin
      ro = AW'(1);
    end else begin
      ro = AW'(0);
    end
    co = AW'(i) - AW'(3) * ro;
    return (r - POS_FIRST + ro) * N_W + (c - POS_FIRST + co);
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    r_d        = r_q;
    c_d        = c_q;
    res_addr_d = res_addr_q;
    res_data_d = res_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          idx_d   = 4'd0;
          r_d     = POS_FIRST;
          c_d     = POS_FIRST;
        end
      end
      S_FETCH: begin
        if (idx_q == 4'd9) begin
          state_d = S_WAIT;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (bus.k_result_valid) begin
          state_d    = S_WRITE;
          res_data_d = bus.k_result;
          res_addr_d = r_q * N_W + c_q;
        end
      end
      S_WRITE: begin
        if (r_q == POS_LAST && c_q == POS_LAST) begin
          state_d = S_DONE;
          r_d     = POS_FIRST;
          c_d     = POS_FIRST;
        end else begin
          state_d = S_FETCH;
          idx_d   = 4'd0;
          if (c_q == POS_LAST) begin
            c_d = POS_FIRST;
            r_d = r_q + AW'(1);
          end else begin
            c_d = c_q + AW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from next-state values so they line up with the state they belong to.
    img_re_d   = (state_d == S_FETCH) && (idx_d <= 4'd8);
    img_addr_d = img_re_d ? nbr_addr(r_d, c_d, idx_d) : img_addr_q;
    k_we_d     = (state_d == S_FETCH) && (idx_d != 4'd0);
    k_id_d     = k_we_d ? {4'd0, idx_d - 4'd1} : k_id_q;
    res_we_d   = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      r_q        <= POS_FIRST;
      c_q        <= POS_FIRST;
      img_re_q   <= 1'b0;
      img_addr_q <= '0;
      k_we_q     <= 1'b0;
      k_id_q     <= 8'd0;
      res_we_q   <= 1'b0;
      res_addr_q <= '0;
      res_data_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      r_q        <= r_d;
      c_q        <= c_d;
      img_re_q   <= img_re_d;
      img_addr_q <= img_addr_d;
      k_we_q     <= k_we_d;
      k_id_q     <= k_id_d;
      res_we_q   <= res_we_d;
      res_addr_q <= res_addr_d;
      res_data_q <= res_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef CHANGE_COUNT_EN
  logic [7:0]  centre_q, centre_d;
  logic [15:0] changed_count_q, changed_count_d;

  // Centre neighbour (i=4) arrives on img_data during FETCH cycle 5.
  always_comb begin
    centre_d        = centre_q;
    changed_count_d = changed_count_q;
    if (state_q == S_FETCH && idx_q == 4'd5) begin
      centre_d = bus.img_data;
    end
    if (state_q == S_IDLE && bus.start) begin
      changed_count_d = 16'd0;
    end else if (state_q == S_WRITE && res_data_q != centre_q && changed_count_q != 16'hFFFF) begin
      changed_count_d = changed_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      centre_q        <= 8'd0;
      changed_count_q <= 16'd0;
    end else begin
      centre_q        <= centre_d;
      changed_count_q <= changed_count_d;
    end
  end

  assign bus.changed_count = changed_count_q;
`else
  assign bus.changed_count = 16'd0;
`endif

  assign bus.img_re   = img_re_q;
  assign bus.img_addr = img_addr_q;
  assign bus.k_we     = k_we_q;
  assign bus.k_id     = k_id_q;
  assign bus.k_data   = bus.img_data;
  assign bus.res_we   = res_we_q;
  assign bus.res_addr = res_addr_q;
  assign bus.res_data = res_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_kernel_window_scheduler.sv
// Bench for kernel_window_scheduler: image RAM and kernel unit are modelled at negedges; expected writes come from a raster-order reference model.
module tb_kernel_window_scheduler;
  localparam int N     = 8;
  localparam int BS    = 6;
  localparam int INNER = N - 2;
  localparam int NPIX  = INNER * INNER;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kernel_window_scheduler_if #(.bitSize(BS)) bus ();
  kernel_window_scheduler #(.N(N), .bitSize(BS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic kv_at_edge = 1'b0;

  logic [7:0]   img_mem [N*N];
  logic [127:0] written;
  int wr_addr[$], wr_data[$], wr_cyc[$], rd_addr[$], rd_cyc[$], kid_q[$], kdat_q[$], kcyc_q[$];
  int valid_viol, done_cnt;
  bit hold_valid, glitch_valid, pending;
  int wait_cycles, kmode, kpix, wcnt;
  logic [8:0][7:0] kbuf;
  int start_cyc, done_cyc, cc_at_done;
  int exp_addr[NPIX], exp_data[NPIX], exp_changed;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    kv_at_edge <= bus.k_result_valid;
  end

  // Kernel function: mode 0 weighted sum, mode 1 centre for pixels 0/7/20/35 else centre+1, mode 2 centre+1.
  function automatic logic [7:0] kernel_fn(input int mode, input int p, input logic [8:0][7:0] nb);
    int s = 0;
    if (mode == 0) begin
      for (int i = 0; i < 9; i++) s += int'(nb[i]) * (i + 1);
      return 8'(s);
    end else if (mode == 1) begin
      return (p == 0 || p == 7 || p == 20 || p == 35) ? nb[4] : nb[4] + 8'd1;
    end
    return nb[4] + 8'd1;
  endfunction

  function automatic void build_model(input int mode);
    logic [8:0][7:0] nb;
    int r, c;
    exp_changed = 0;
    for (int p = 0; p < NPIX; p++) begin
      r = 1 + p / INNER;
      c = 1 + p % INNER;
      for (int i = 0; i < 9; i++) nb[i] = img_mem[(r - 1 + i / 3) * N + (c - 1 + i % 3)];
      exp_addr[p] = r * N + c;
      exp_data[p] = int'(kernel_fn(mode, p, nb));
      if (exp_data[p] != int'(nb[4])) exp_changed++;
    end
  endfunction

  // Monitor, image RAM and kernel unit, all acting at the falling edge.
  initial begin
    logic kv;
    forever begin
      @(negedge clk);
      if (bus.res_we) begin
        wr_addr.push_back(int'(bus.res_addr));
        wr_data.push_back(int'(bus.res_data));
        wr_cyc.push_back(cyc);
        written[bus.res_addr] = 1'b1;
        if (!kv_at_edge) valid_viol++;
      end
      if (bus.done) done_cnt++;
      if (bus.img_re) begin
        rd_addr.push_back(int'(bus.img_addr));
        rd_cyc.push_back(cyc);
      end
      kv = 1'b0;
      if (pending) begin
        wcnt++;
        if (wcnt >= wait_cycles) begin
          kv = 1'b1;
          pending = 1'b0;
        end
      end
      if (bus.k_we) begin
        kid_q.push_back(int'(bus.k_id));
        kdat_q.push_back(int'(bus.k_data));
        kcyc_q.push_back(cyc);
        if (bus.k_id < 8'd9) kbuf[bus.k_id[3:0]] = bus.k_data;
        if (bus.k_id == 8'd8) begin
          pending = 1'b1;
          wcnt = 0;
          kpix++;
        end
      end
      if (hold_valid || (glitch_valid && bus.k_we)) kv = 1'b1;
      bus.k_result       = kernel_fn(kmode, kpix - 1, kbuf);
      bus.k_result_valid = kv;
      bus.img_data       = bus.img_re ? img_mem[bus.img_addr[5:0]] : bus.img_data;
    end
  end

  task automatic start_pass();
    @(negedge clk); #1;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); rd_addr.delete(); rd_cyc.delete();
    kid_q.delete(); kdat_q.delete(); kcyc_q.delete();
    written = '0; valid_viol = 0; done_cnt = 0; kpix = 0; pending = 1'b0;
    bus.start = 1'b1;
    start_cyc = cyc;
    @(negedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (bus.done) begin
        ok = 1'b1;
        done_cyc = cyc;
        cc_at_done = int'(bus.changed_count);
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({bus.img_re, bus.k_we, bus.res_we, bus.busy, bus.done} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {bus.img_re, bus.k_we, bus.res_we, bus.busy, bus.done});
    end
    checks++;
    if ({bus.img_addr, bus.res_addr, bus.k_id, bus.res_data, bus.changed_count} !== '0) begin
      errors++; $display("FAIL reset_data got img_addr %0d res_addr %0d k_id %0d res_data %0d cc %0d exp all 0",
                         bus.img_addr, bus.res_addr, bus.k_id, bus.res_data, bus.changed_count);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.img_re !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got busy %b img_re %b exp 0 0", bus.busy, bus.img_re);
    end
  endtask

  task automatic test_spec_example();
    bit ok;
    int pad_hits = 0;
    for (int a = 0; a < N * N; a++) img_mem[a] = 8'(a);
    hold_valid = 1'b1; glitch_valid = 1'b0; wait_cycles = 1; kmode = 2;
    start_pass();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_rise got %b exp 1", bus.busy); end
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL spec_done_timeout got no done exp done"); end
    checks++;
    if (done_cyc - start_cyc !== 433) begin
      errors++; $display("FAIL spec_done_cycle got %0d exp 433", done_cyc - start_cyc);
    end
    for (int i = 0; i < 9; i++) begin
      int ea;
      ea = (i / 3) * N + i % 3;
      checks++;
      if (rd_addr[i] !== ea || rd_cyc[i] !== start_cyc + 1 + i) begin
        errors++; $display("FAIL fetch_addr[%0d] got %0d@%0d exp %0d@%0d", i, rd_addr[i], rd_cyc[i] - start_cyc, ea, 1 + i);
      end
      checks++;
      if (kid_q[i] !== i || kcyc_q[i] !== start_cyc + 2 + i || kdat_q[i] !== ea) begin
        errors++; $display("FAIL k_load[%0d] got id %0d data %0d @%0d exp id %0d data %0d @%0d",
                           i, kid_q[i], kdat_q[i], kcyc_q[i] - start_cyc, i, ea, 2 + i);
      end
    end
    checks++;
    if (wr_addr.size() !== NPIX) begin errors++; $display("FAIL spec_write_count got %0d exp %0d", wr_addr.size(), NPIX); end
    checks++;
    if (wr_addr[0] !== 9 || wr_data[0] !== 10) begin
      errors++; $display("FAIL spec_first_write got %0d/%0d exp 9/10", wr_addr[0], wr_data[0]);
    end
    checks++;
    if (wr_addr[wr_addr.size() - 1] !== 54 || wr_data[wr_data.size() - 1] !== 55) begin
      errors++; $display("FAIL spec_last_write got %0d/%0d exp 54/55", wr_addr[wr_addr.size() - 1], wr_data[wr_data.size() - 1]);
    end
    for (int a = 0; a < 128; a++)
      if (written[a] && (a >= N * N || a / N == 0 || a / N == N - 1 || a % N == 0 || a % N == N - 1)) pad_hits++;
    checks++;
    if (pad_hits !== 0) begin errors++; $display("FAIL padding_writes got %0d exp 0", pad_hits); end
    @(negedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL busy_fall got busy %b done %b exp 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_random_pass(input int w, input bit hold, input int exp_period, input string tag);
    bit ok;
    int bad_sp = 0;
    for (int a = 0; a < N * N; a++) img_mem[a] = 8'($urandom_range(0, 255));
    hold_valid = hold; glitch_valid = 1'b0; wait_cycles = w; kmode = 0;
    build_model(0);
    start_pass();
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_done_timeout got no done exp done", tag); end
    checks++;
    if (wr_addr.size() !== NPIX) begin errors++; $display("FAIL %s_write_count got %0d exp %0d", tag, wr_addr.size(), NPIX); end
    for (int p = 0; p < NPIX && p < wr_addr.size(); p++) begin
      checks++;
      if (wr_addr[p] !== exp_addr[p] || wr_data[p] !== exp_data[p]) begin
        errors++; $display("FAIL %s_write[%0d] got %0d/%0d exp %0d/%0d", tag, p, wr_addr[p], wr_data[p], exp_addr[p], exp_data[p]);
      end
      if (p > 0 && wr_cyc[p] - wr_cyc[p - 1] != exp_period) bad_sp++;
    end
    checks++;
    if (bad_sp !== 0) begin errors++; $display("FAIL %s_pixel_period got %0d bad gaps exp 0 (period %0d)", tag, bad_sp, exp_period); end
    checks++;
    if (done_cyc - start_cyc !== NPIX * exp_period + 1) begin
      errors++; $display("FAIL %s_done_cycle got %0d exp %0d", tag, done_cyc - start_cyc, NPIX * exp_period + 1);
    end
    checks++;
    if (valid_viol !== 0) begin errors++; $display("FAIL %s_write_without_valid got %0d exp 0", tag, valid_viol); end
  endtask

  task automatic test_ignore_start_and_glitch();
    bit ok = 1'b0;
    for (int a = 0; a < N * N; a++) img_mem[a] = 8'($urandom_range(0, 255));
    hold_valid = 1'b0; glitch_valid = 1'b1; wait_cycles = 2; kmode = 0;
    build_model(0);
    start_pass();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      bus.start = (i == 40 || i == 300);
      if (bus.done) begin
        ok = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL ignore_done_timeout got no done exp done"); end
    checks++;
    if (done_cyc - start_cyc !== NPIX * 13 + 1) begin
      errors++; $display("FAIL ignore_done_cycle got %0d exp %0d", done_cyc - start_cyc, NPIX * 13 + 1);
    end
    for (int p = 0; p < NPIX && p < wr_addr.size(); p++) begin
      checks++;
      if (wr_addr[p] !== exp_addr[p] || wr_data[p] !== exp_data[p]) begin
        errors++; $display("FAIL ignore_write[%0d] got %0d/%0d exp %0d/%0d", p, wr_addr[p], wr_data[p], exp_addr[p], exp_data[p]);
      end
    end
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (wr_addr.size() !== NPIX || done_cnt !== 1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL ignore_no_requeue got writes %0d dones %0d busy %b exp %0d 1 0", wr_addr.size(), done_cnt, bus.busy, NPIX);
    end
    glitch_valid = 1'b0;
  endtask

  task automatic test_reset_mid_pass();
    bit ok;
    int guard = 0;
    for (int a = 0; a < N * N; a++) img_mem[a] = 8'($urandom_range(0, 255));
    hold_valid = 1'b0; glitch_valid = 1'b0; wait_cycles = 3; kmode = 0;
    build_model(0);
    start_pass();
    while (kpix != 10 && guard < 3000) begin
      @(negedge clk); #1;
      guard++;
    end
    checks++;
    if (kpix != 10) begin errors++; $display("FAIL midreset_reach_pixel10 got %0d exp 10", kpix); end
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.img_re, bus.k_we, bus.res_we, bus.busy, bus.done} !== 5'b0) begin
      errors++; $display("FAIL midreset_ctrl got %b exp 00000", {bus.img_re, bus.k_we, bus.res_we, bus.busy, bus.done});
    end
    checks++;
    if ({bus.img_addr, bus.res_addr, bus.k_id, bus.res_data} !== '0) begin
      errors++; $display("FAIL midreset_data got %0d %0d %0d %0d exp 0 0 0 0", bus.img_addr, bus.res_addr, bus.k_id, bus.res_data);
    end
    checks++;
    if (wr_addr.size() !== 9) begin errors++; $display("FAIL midreset_writes_before got %0d exp 9", wr_addr.size()); end
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (wr_addr.size() !== 9 || done_cnt !== 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midreset_quiet got writes %0d dones %0d busy %b exp 9 0 0", wr_addr.size(), done_cnt, bus.busy);
    end
    start_pass();
    wait_done(ok);
    checks++;
    if (!ok || wr_addr.size() !== NPIX) begin
      errors++; $display("FAIL midreset_restart got done %b writes %0d exp 1 %0d", ok, wr_addr.size(), NPIX);
    end
    checks++;
    if (wr_addr[0] !== 9 || wr_data[0] !== exp_data[0]) begin
      errors++; $display("FAIL midreset_first_write got %0d/%0d exp 9/%0d", wr_addr[0], wr_data[0], exp_data[0]);
    end
  endtask

  task automatic test_change_count();
    bit ok;
    int exp_cc;
    for (int a = 0; a < N * N; a++) img_mem[a] = 8'($urandom_range(0, 255));
    hold_valid = 1'b1; glitch_valid = 1'b0; wait_cycles = 1; kmode = 1;
    build_model(1);
`ifdef CHANGE_COUNT_EN
    exp_cc = exp_changed;
`else
    exp_cc = 0;
`endif
    start_pass();
    checks++;
    if (bus.changed_count !== 16'd0) begin errors++; $display("FAIL cc_cleared got %0d exp 0", bus.changed_count); end
    wait_done(ok);
    checks++;
    if (!ok || cc_at_done !== exp_cc) begin
      errors++; $display("FAIL cc_at_done got %0d (done %b) exp %0d", cc_at_done, ok, exp_cc);
    end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (int'(bus.changed_count) !== exp_cc) begin
      errors++; $display("FAIL cc_hold got %0d exp %0d", bus.changed_count, exp_cc);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.k_result = 8'd0;
    bus.k_result_valid = 1'b0;
    bus.img_data = 8'd0;
    kbuf = '0;
    written = '0;
    hold_valid = 1'b0; glitch_valid = 1'b0; pending = 1'b0;
    wait_cycles = 1; kmode = 0; kpix = 0; wcnt = 0;
    valid_viol = 0; done_cnt = 0;
    test_reset();
    test_spec_example();
    test_random_pass(1, 1'b1, 12, "hold");
    test_random_pass(5, 1'b0, 16, "wait5");
    test_ignore_start_and_glitch();
    test_reset_mid_pass();
    test_change_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
